// File: rtl/gf_mod_mul_seq.sv
// Sequential GF(2^M) unit: polynomial reduction mod f(x) (mode 0) or
// bit-serial MSB-first multiply a*b mod f(x) (mode 1), valid/ready on both sides.
module gf_mod_mul_seq #(
    parameter int unsigned M    = 7,
    parameter logic [M:0]  POLY = 8'hBF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_mode,
    input  logic [2*M-2:0] in_d,
    input  logic [M-1:0]   in_a,
    input  logic [M-1:0]   in_b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [M-1:0]   out_r,
    output logic           busy
);

    localparam int unsigned DW = 2 * M - 1;     // accumulator width (mode 0 is the wider case)
    localparam int unsigned CW = $clog2(2 * M); // bit index width

    if (M < 2 || POLY[M] != 1'b1) begin : gen_param_check
        $error("gf_mod_mul_seq: M must be >= 2 and POLY[M] must be 1");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mode_q, mode_d;
    logic [M-1:0]  a_q, a_d;
    logic [M-1:0]  b_q, b_d;
    logic [M-1:0]  out_r_q, out_r_d;

    logic          acc_bit;
    logic          b_bit;
    logic [DW-1:0] poly_sh;
    logic [DW-1:0] red_step;
    logic [M-1:0]  mul_step;
    logic          last_step;

    // One-step datapath for both modes, indexed by the current bit counter
    always_comb begin
        acc_bit  = |(acc_q & (DW'(1) << cnt_q));
        poly_sh  = DW'(POLY) << (cnt_q - CW'(M));
        red_step = acc_q ^ (acc_bit ? poly_sh : '0);
        b_bit    = |(b_q & (M'(1) << cnt_q));
        // Shift left; the bit that would land at x^M is folded back with the low part of f(x)
        mul_step = {acc_q[M-2:0], 1'b0}
                 ^ (acc_q[M-1] ? POLY[M-1:0] : '0)
                 ^ (b_bit ? a_q : '0);
        // Mode 0 stops after processing x^M, mode 1 after multiplier bit 0
        last_step = mode_q ? (cnt_q == '0) : (cnt_q == CW'(M));
    end

    // Next-state logic for the IDLE / RUN / DONE controller
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        a_d     = a_q;
        b_d     = b_q;
        out_r_d = out_r_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    mode_d  = in_mode;
                    a_d     = in_a;
                    b_d     = in_b;
                    state_d = StRun;
                    if (in_mode) begin
                        acc_d = '0;
                        cnt_d = CW'(M - 1);
                    end else begin
                        acc_d = in_d;
                        cnt_d = CW'(2 * M - 2);
                    end
                end
            end
            StRun: begin
                acc_d = mode_q ? DW'(mul_step) : red_step;
                if (last_step) begin
                    state_d = StDone;
                    out_r_d = acc_d[M-1:0];
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            out_r_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            a_q     <= a_d;
            b_q     <= b_d;
            out_r_q <= out_r_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign out_r     = out_r_q;

endmodule
